alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, datapath width; power of two, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous drop of all in-flight ops.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  stage can accept request.
REQ-007 SHALL have port in_unit  input  2  ALU submodule select: 0 ARITHMETIC, 1 LOGIC, 2 LSHIFT, 3 RSHIFT.
REQ-008 SHALL have port in_op  input  2  submodule op code, passed to the ALU unchanged.
REQ-009 SHALL have ports in_a, in_b  input  BIT_WIDTH  operands; B is the shift amount for shift units.
REQ-010 SHALL have port in_flags_we  input  1  op updates the flag register; honoured only for ARITHMETIC.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_r  output  BIT_WIDTH  registered result.
REQ-014 SHALL have ports out_cf, out_of, out_zf  output  1 each  current flag-register contents.

Function
REQ-015 SHALL be a two-register pipeline: S1 (operand register) feeding an internal ALU instance, then S2 (result register) driving out_*.
REQ-016 SHALL accept a request when in_valid && in_ready; the fields are captured into S1 on that edge.
REQ-017 SHALL define advance = !S2.valid || out_ready; in_ready = !S1.valid || advance, combinational and with no dependency on in_valid.
REQ-018 SHALL, on advance with S1.valid, capture the ALU output of the S1 unit into out_r and set out_valid; on advance without S1.valid, clear out_valid.
REQ-019 SHALL give a latency of 2 cycles: a request accepted at edge N has out_valid high after edge N+1; throughput 1 op/cycle with out_ready held high.
REQ-020 SHALL drive the operand/op inputs of the ALU unit selected by S1.unit from S1, and drive all other units' inputs to zero.
REQ-021 SHALL drive the ALU carry input from the flag-register CF.
REQ-022 SHALL update {CF,OF,ZF} from the ALU flag outputs on the S1->S2 transfer only when S1.unit==ARITHMETIC && S1.flags_we; all other transfers leave flags unchanged.
REQ-023 SHALL guarantee back-to-back carry ops see the previous op's CF (flags are written on the same edge that the next op becomes visible in S1), with no stall.
REQ-024 SHALL hold S1, S2 and flags stable while out_valid && !out_ready; no op is lost or duplicated, and order is preserved.
REQ-025 SHALL, on flush, clear S1.valid and out_valid on the next edge, ignore any same-cycle input handshake, and leave flags unchanged.
REQ-026 SHALL give reset priority over flush, and flush priority over the handshake.

Reset
REQ-027 SHALL clear S1.valid, out_valid, out_r, CF, OF and ZF to 0 on the edge where reset is high.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset.
REQ-029 SHALL silently discard in-flight ops when reset is asserted mid-operation.

Structure
REQ-030 SHALL place the submodule enum (ARITHMETIC..RSHIFT) and a flags struct {cf,of,zf} in shared package alu_pkg.
REQ-031 SHALL instantiate exactly one sub-module, ALU, with bit_width=BIT_WIDTH; no arithmetic is duplicated in this block.

Verification
REQ-032 SHALL cover the basic add: BIT_WIDTH=4, unit=0 op=00 A=3 B=5 we=1 -> out_r=8, CF=0, ZF=0, out_valid two edges after acceptance.
REQ-033 SHALL cover a carry chain: unit=0 op=00 A=F B=1 we=1, then unit=0 op=10 A=0 B=0 back-to-back -> out_r=0 with CF=1 and ZF=1, then out_r=1.
REQ-034 SHALL cover logic ops with flags held: CF=1, then unit=1 op=01 A=C B=A -> out_r=8 and CF stays 1; op=00 A=C -> out_r=3.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles while 4 ops are offered -> in_ready low after 2 accepted, then all 4 results delivered in order once out_ready=1.
REQ-036 SHALL cover flush: flush with 2 ops in flight -> out_valid=0 next cycle, flags unchanged, next accepted op returns correctly.
REQ-037 SHALL cover reset mid-operation: reset with out_valid=1 and CF=1 -> out_valid=0, out_r=0, CF=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: unit select encoding, flag bundle
// and the LOGIC unit op codes.
package alu_pkg;

    typedef enum logic [1:0] {
        ARITHMETIC = 2'd0,
        LOGIC      = 2'd1,
        LSHIFT     = 2'd2,
        RSHIFT     = 2'd3
    } unit_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
    } flags_t;

    localparam logic [1:0] OP_NOT = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU with four independent units. Arithmetic: 00 ADD, 01 SUB,
// 10 ADC, 11 SBB. Shifts: op[0] selects rotate, LSHIFT op[1] forces amount 1, RSHIFT op[1] is SRA.
module alu
    import alu_pkg::*;
#(
    parameter int bit_width = 4
) (
    input  logic [bit_width-1:0] arith_a,
    input  logic [bit_width-1:0] arith_b,
    input  logic [1:0]           arith_op,
    input  logic                 arith_cin,
    input  logic [bit_width-1:0] logic_a,
    input  logic [bit_width-1:0] logic_b,
    input  logic [1:0]           logic_op,
    input  logic [bit_width-1:0] lsh_a,
    input  logic [bit_width-1:0] lsh_b,
    input  logic [1:0]           lsh_op,
    input  logic [bit_width-1:0] rsh_a,
    input  logic [bit_width-1:0] rsh_b,
    input  logic [1:0]           rsh_op,
    output logic [bit_width-1:0] arith_r,
    output logic                 arith_cf,
    output logic                 arith_of,
    output logic                 arith_zf,
    output logic [bit_width-1:0] logic_r,
    output logic [bit_width-1:0] lsh_r,
    output logic [bit_width-1:0] rsh_r
);

    localparam int SH_W = $clog2(bit_width);
    localparam logic [bit_width-1:0] SHIFT_ONE = {{(bit_width-1){1'b0}}, 1'b1};

    logic [bit_width-1:0]        b_eff;
    logic                        cin_eff;
    logic [bit_width:0]          sum;
    logic [bit_width-1:0]        lsh_amt;
    logic [bit_width-1:0]        rol_v;
    logic [bit_width-1:0]        ror_v;
    logic signed [bit_width-1:0] rsh_a_s;

    // Subtraction is a + ~b + 1; with borrow-in the +1 becomes !cin, and CF reports borrow.
    always_comb begin
        b_eff    = arith_op[0] ? ~arith_b : arith_b;
        cin_eff  = arith_op[1] ? (arith_cin ^ arith_op[0]) : arith_op[0];
        sum      = {1'b0, arith_a} + {1'b0, b_eff} + {{bit_width{1'b0}}, cin_eff};
        arith_r  = sum[bit_width-1:0];
        arith_cf = sum[bit_width] ^ arith_op[0];
        arith_of = (arith_a[bit_width-1] == b_eff[bit_width-1]) &&
                   (arith_r[bit_width-1] != arith_a[bit_width-1]);
        arith_zf = (arith_r == '0);
    end

    always_comb begin
        case (logic_op)
            OP_NOT:  logic_r = ~logic_a;
            OP_AND:  logic_r = logic_a & logic_b;
            OP_OR:   logic_r = logic_a | logic_b;
            default: logic_r = logic_a ^ logic_b;
        endcase
    end

    // Rotate indices wrap naturally because bit_width is a power of two.
    always_comb begin
        logic [SH_W-1:0] rot;
        lsh_amt = lsh_op[1] ? SHIFT_ONE : lsh_b;
        rot     = lsh_amt[SH_W-1:0];
        rol_v   = '0;
        for (int i = 0; i < bit_width; i++) begin
            rol_v[i] = lsh_a[SH_W'(i) - rot];
        end
        lsh_r = lsh_op[0] ? rol_v : (lsh_a << lsh_amt);
    end

    always_comb begin
        logic [SH_W-1:0] rot;
        rot     = rsh_b[SH_W-1:0];
        rsh_a_s = rsh_a;
        ror_v   = '0;
        for (int i = 0; i < bit_width; i++) begin
            ror_v[i] = rsh_a[SH_W'(i) + rot];
        end
        case (rsh_op)
            2'd0:    rsh_r = rsh_a >> rsh_b;
            2'd1:    rsh_r = ror_v;
            default: rsh_r = rsh_a_s >>> rsh_b;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register ALU execute stage: operand register S1 feeds the ALU, result
// register S2 drives the outputs; the flag register updates on S1->S2 arithmetic ops.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_unit,
    input  logic [1:0]           in_op,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic                 in_flags_we,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_r,
    output logic                 out_cf,
    output logic                 out_of,
    output logic                 out_zf
);

    logic                 vld_p1;
    unit_e                unit_p1;
    logic [1:0]           op_p1;
    logic [BIT_WIDTH-1:0] a_p1;
    logic [BIT_WIDTH-1:0] b_p1;
    logic                 we_p1;

    logic                 vld_p2;
    logic [BIT_WIDTH-1:0] r_p2;
    flags_t               flags_q;

    logic                 advance;
    logic                 accept;

    logic [BIT_WIDTH-1:0] arith_a, arith_b, logic_a, logic_b;
    logic [BIT_WIDTH-1:0] lsh_a, lsh_b, rsh_a, rsh_b;
    logic [1:0]           arith_op, logic_op, lsh_op, rsh_op;
    logic [BIT_WIDTH-1:0] arith_r, logic_r, lsh_r, rsh_r, alu_r;
    logic                 arith_cf, arith_of, arith_zf;

    assign advance  = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || advance;
    assign accept   = in_valid && in_ready;

    // ---- S1: operand register ----
    always_ff @(posedge clk) begin
        if (accept) begin
            unit_p1 <= unit_e'(in_unit);
            op_p1   <= in_op;
            a_p1    <= in_a;
            b_p1    <= in_b;
            we_p1   <= in_flags_we;
        end
    end

    // Idle units see zeros so only the selected unit toggles.
    always_comb begin
        arith_a  = '0;
        arith_b  = '0;
        arith_op = '0;
        logic_a  = '0;
        logic_b  = '0;
        logic_op = '0;
        lsh_a    = '0;
        lsh_b    = '0;
        lsh_op   = '0;
        rsh_a    = '0;
        rsh_b    = '0;
        rsh_op   = '0;
        case (unit_p1)
            ARITHMETIC: begin arith_a = a_p1; arith_b = b_p1; arith_op = op_p1; end
            LOGIC:      begin logic_a = a_p1; logic_b = b_p1; logic_op = op_p1; end
            LSHIFT:     begin lsh_a   = a_p1; lsh_b   = b_p1; lsh_op   = op_p1; end
            default:    begin rsh_a   = a_p1; rsh_b   = b_p1; rsh_op   = op_p1; end
        endcase
    end

    always_comb begin
        case (unit_p1)
            ARITHMETIC: alu_r = arith_r;
            LOGIC:      alu_r = logic_r;
            LSHIFT:     alu_r = lsh_r;
            default:    alu_r = rsh_r;
        endcase
    end

    alu #(
        .bit_width (BIT_WIDTH)
    ) u_alu (
        .arith_a   (arith_a),
        .arith_b   (arith_b),
        .arith_op  (arith_op),
        .arith_cin (flags_q.cf),
        .logic_a   (logic_a),
        .logic_b   (logic_b),
        .logic_op  (logic_op),
        .lsh_a     (lsh_a),
        .lsh_b     (lsh_b),
        .lsh_op    (lsh_op),
        .rsh_a     (rsh_a),
        .rsh_b     (rsh_b),
        .rsh_op    (rsh_op),
        .arith_r   (arith_r),
        .arith_cf  (arith_cf),
        .arith_of  (arith_of),
        .arith_zf  (arith_zf),
        .logic_r   (logic_r),
        .lsh_r     (lsh_r),
        .rsh_r     (rsh_r)
    );

    // ---- S2: result register and flags ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            r_p2    <= '0;
            flags_q <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (advance) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    r_p2 <= alu_r;
                    if (unit_p1 == ARITHMETIC && we_p1) begin
                        flags_q <= '{cf: arith_cf, of: arith_of, zf: arith_zf};
                    end
                end
            end
            if (accept) begin
                vld_p1 <= 1'b1;
            end else if (advance) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_r     = r_p2;
    assign out_cf    = flags_q.cf;
    assign out_of    = flags_q.of;
    assign out_zf    = flags_q.zf;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a behavioural model queues expected
// {result, flags} at acceptance, and a monitor compares on each output handshake.
module tb_alu_exec_stage;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, in_flags_we;
    logic [1:0]   in_unit, in_op;
    logic [W-1:0] in_a, in_b, out_r;
    logic         out_valid, out_ready, out_cf, out_of, out_zf;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cf;
        logic         of;
        logic         zf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   nvec = 0;
    int   nmis = 0;
    int   acc_cnt = 0;
    logic m_cf = 1'b0, m_of = 1'b0, m_zf = 1'b0;
    bit   rand_bp = 1'b0;

    alu_exec_stage #(.BIT_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_unit     (in_unit),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_flags_we (in_flags_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_cf      (out_cf),
        .out_of      (out_of),
        .out_zf      (out_zf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    task automatic model_push(input logic [1:0] unit, input logic [1:0] op,
                              input int a, input int b, input logic we);
        int   res, c, sr, amt;
        logic ncf;
        logic [W-1:0] rv;
        res = 0;
        case (unit)
            2'd0: begin
                c = op[1] ? int'(m_cf) : 0;
                if (!op[0]) begin
                    res = a + b + c;
                    sr  = to_signed(a) + to_signed(b) + c;
                    ncf = (res > MASK);
                end else begin
                    res = a - b - c;
                    sr  = to_signed(a) - to_signed(b) - c;
                    ncf = (res < 0);
                end
                res = res & MASK;
                if (we) begin
                    m_cf = ncf;
                    m_of = (sr > HALF - 1) || (sr < -HALF);
                    m_zf = (res == 0);
                end
            end
            2'd1: begin
                case (op)
                    2'd0: res = ~a & MASK;
                    2'd1: res = a & b;
                    2'd2: res = a | b;
                    default: res = a ^ b;
                endcase
            end
            2'd2: begin
                amt = op[1] ? 1 : b;
                if (op[0]) res = ((a << (amt % W)) | (a >> (W - amt % W))) & MASK;
                else       res = (a << amt) & MASK;
            end
            default: begin
                case (op)
                    2'd0: res = a >> b;
                    2'd1: res = ((a >> (b % W)) | (a << (W - b % W))) & MASK;
                    default: res = (to_signed(a) >>> b) & MASK;
                endcase
            end
        endcase
        rv = res[W-1:0];
        sb_q.push_back({rv, m_cf, m_of, m_zf});
    endtask

    // Returns just after the accepting edge with in_valid still high.
    task automatic send(input logic [1:0] unit, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic we);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_unit = unit; in_op = op;
        in_a = a; in_b = b; in_flags_we = we;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("hs_timeout", 1, 0);
            in_valid = 1'b0;
            return;
        end
        model_push(unit, op, int'(a), int'(b), we);
        acc_cnt++;
        @(posedge clk);
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", {out_r, out_cf, out_of, out_zf}, mon_e);
            end
        end
    end

    always @(negedge clk) begin
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_unit = '0; in_op = '0;
        in_a = '0; in_b = '0; in_flags_we = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_r", out_r, 0);
        chk("rst_flags", {out_cf, out_of, out_zf}, 0);
        chk("rst_ready", in_ready, 1);

        // Basic add and two-edge latency
        send(2'd0, 2'd0, 4'd3, 4'd5, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("lat_n1", out_valid, 0);
        @(negedge clk); #1;
        chk("lat_n2", out_valid, 1);
        chk("add_r", out_r, 8);
        chk("add_cf_zf", {out_cf, out_zf}, 0);

        // Carry chain: ADC sees the CF written by the previous op
        send(2'd0, 2'd0, 4'hF, 4'h1, 1'b1);
        send(2'd0, 2'd2, 4'h0, 4'h0, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("carry_r", out_r, 0);
        chk("carry_cf_zf", {out_cf, out_zf}, 2'b11);
        @(negedge clk); #1;
        chk("adc_r", out_r, 1);

        // Logic ops leave CF=1 untouched
        send(2'd0, 2'd0, 4'hF, 4'h1, 1'b1);
        send(2'd1, 2'd1, 4'hC, 4'hA, 1'b0);
        send(2'd1, 2'd0, 4'hC, 4'h0, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        chk("and_r", out_r, 8);
        chk("and_cf", out_cf, 1);
        @(negedge clk); #1;
        chk("not_r", out_r, 3);
        chk("not_cf", out_cf, 1);
        drain();

        // Backpressure: only two ops fit while out_ready is low
        @(negedge clk); out_ready = 1'b0; acc_cnt = 0;
        fork
            begin
                send(2'd0, 2'd0, 4'd1, 4'd2, 1'b1);
                send(2'd0, 2'd1, 4'd7, 4'd9, 1'b1);
                send(2'd0, 2'd2, 4'd4, 4'd4, 1'b1);
                send(2'd0, 2'd3, 4'd2, 4'd6, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                chk("bp_accepted", acc_cnt, 2);
                chk("bp_ready", in_ready, 0);
                @(negedge clk); out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two ops in flight
        @(negedge clk); out_ready = 1'b0;
        send(2'd1, 2'd3, 4'd5, 4'd3, 1'b0);
        send(2'd1, 2'd2, 4'd8, 4'd1, 1'b0);
        @(negedge clk); in_valid = 1'b0; flush = 1'b1; sb_q.delete();
        @(negedge clk); flush = 1'b0; out_ready = 1'b1; #1;
        chk("fl_vld", out_valid, 0);
        chk("fl_flags", {out_cf, out_of, out_zf}, {m_cf, m_of, m_zf});
        chk("fl_ready", in_ready, 1);

        // Flush beats a same-cycle handshake
        send(2'd2, 2'd0, 4'd3, 4'd1, 1'b0);
        @(negedge clk); flush = 1'b1; in_unit = 2'd3; in_a = 4'd9; sb_q.delete();
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
        chk("flhs_vld1", out_valid, 0);
        @(negedge clk); #1;
        chk("flhs_vld2", out_valid, 0);
        send(2'd0, 2'd1, 4'd2, 4'd7, 1'b1);
        drain();

        // Reset mid-operation with a held result and CF=1
        @(negedge clk); out_ready = 1'b0;
        send(2'd0, 2'd0, 4'hF, 4'h2, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        chk("pre_rst_vld", out_valid, 1);
        chk("pre_rst_cf", out_cf, 1);
        @(negedge clk); reset = 1'b1; sb_q.delete();
        m_cf = 1'b0; m_of = 1'b0; m_zf = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_r", out_r, 0);
        chk("mid_rst_cf", out_cf, 0);
        chk("mid_rst_ready", in_ready, 1);

        // Random mix under random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 60; k++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 W'($urandom_range(0, MASK)), W'($urandom_range(0, MASK)),
                 1'($urandom_range(0, 1)));
        end
        @(negedge clk); in_valid = 1'b0; rand_bp = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
